// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with configurable wait states, per-byte writes,
// a side-band program loader and a combinational debug peek port.
//
// state | meaning
// IDLE  | no transaction in progress; waitrequest mirrors read|write
// BUSY  | transaction in progress; cnt counts remaining stall cycles
module avalon_wait_ram #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH_WORDS     = 1024,
    parameter int WAIT_CYCLES     = 2,
    parameter int LOAD_ADDR_WIDTH = 8,
    parameter bit CLEAR_ON_RESET  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic                       read,
    input  logic                       write,
    input  logic [DATA_WIDTH-1:0]      writedata,
    input  logic [DATA_WIDTH/8-1:0]    byteenable,
    output logic                       waitrequest,
    output logic [DATA_WIDTH-1:0]      readdata,
    input  logic                       inst_input,
    input  logic [LOAD_ADDR_WIDTH-1:0] inst_addr,
    input  logic [DATA_WIDTH-1:0]      instruction,
    input  logic [ADDR_WIDTH-1:0]      dbg_addr,
    output logic [DATA_WIDTH-1:0]      dbg_data
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = $clog2(DEPTH_WORDS);
    localparam int IDX_LSB  = $clog2(BE_WIDTH);
    localparam int CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] bus_idx;
    logic [IDX_W-1:0] load_idx;
    logic [IDX_W-1:0] dbg_idx;
    logic             req;
    logic             is_rd;
    logic             rd_load;
    logic             unused_bits;

    // Casting to IDX_W drops the high bits, which gives the modulo-depth aliasing.
    assign bus_idx  = IDX_W'(address >> IDX_LSB);
    assign load_idx = IDX_W'(inst_addr >> IDX_LSB);
    assign dbg_idx  = IDX_W'(dbg_addr >> IDX_LSB);

    assign req   = read | write;
    assign is_rd = read & ~write;

    // readdata is captured on the edge that leaves cnt at zero.
    assign rd_load = is_rd && !inst_input &&
                     (((state == ST_IDLE) && (WAIT_CYCLES == 0)) ||
                      ((state == ST_BUSY) && (cnt == CNT_ONE)));

    always_comb begin
        waitrequest = 1'b1;
        if (inst_input) begin
            waitrequest = 1'b1;
        end else if (state == ST_IDLE) begin
            waitrequest = req;
        end else begin
            waitrequest = (cnt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            readdata <= '0;
            if (CLEAR_ON_RESET) begin
                for (int i = 0; i < DEPTH_WORDS; i++) begin
                    mem[i] <= '0;
                end
            end
        end else begin
            if (inst_input) begin
                mem[load_idx] <= instruction;
                state         <= ST_IDLE;
                cnt           <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req) begin
                            state <= ST_BUSY;
                            cnt   <= CNT_START;
                        end
                    end
                    ST_BUSY: begin
                        if (!req) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            if (write) begin
                                for (int b = 0; b < BE_WIDTH; b++) begin
                                    if (byteenable[b]) begin
                                        mem[bus_idx][8*b +: 8] <= writedata[8*b +: 8];
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
            if (rd_load) begin
                readdata <= mem[bus_idx];
            end
        end
    end

    assign dbg_data = mem[dbg_idx];

    assign unused_bits = ^{address, inst_addr, dbg_addr};

endmodule
